// File: rtl/fpu_ctrl_div_sqrt_pkg.sv
// Shared types and constants for the iterative div/sqrt controller.
package fpu_defs_div_sqrt_tp;

    localparam int unsigned C_DIV_MANT_W   = 24;
    localparam int unsigned C_DIV_PREC_W   = 6;
    localparam int unsigned C_DIV_RM       = 3;
    localparam int unsigned C_DIV_ITER_W   = 5;
    localparam int unsigned C_DIV_GUARD_IT = 3;
    localparam int unsigned C_DIV_MIN_PREC = 6;

    typedef enum logic [1:0] {IDLE, ITER, NORM, DONE} div_sqrt_state_t;

    // Operation attributes latched on accept and held until the next accept
    typedef struct packed {
        logic                op_div;
        logic [C_DIV_RM-1:0] rm;
    } div_sqrt_op_t;

endpackage

// File: rtl/fpu_ctrl_div_sqrt_iter_cnt.sv
// Iteration index counter: synchronous clear beats enable; flags the final iteration.
module fpu_iter_cnt_div_sqrt
    import fpu_defs_div_sqrt_tp::*;
#(
    parameter int unsigned W = C_DIV_ITER_W
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         clear_i,
    input  logic         en_i,
    input  logic [W-1:0] limit_i,
    output logic [W-1:0] count_o,
    output logic         last_c_o
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign count_o  = cnt_q;
    assign last_c_o = (cnt_q == limit_i - W'(1));

endmodule

// File: rtl/fpu_ctrl_div_sqrt.sv
// Sequencing controller for the radix-2 div/sqrt unit: accept, iterate N cycles,
// normalise for one cycle, then hold the result under valid/ready backpressure.
module fpu_ctrl_div_sqrt
    import fpu_defs_div_sqrt_tp::*;
#(
    parameter int unsigned MANT_W   = C_DIV_MANT_W,
    parameter int unsigned PREC_W   = C_DIV_PREC_W,
    parameter int unsigned GUARD_IT = C_DIV_GUARD_IT
) (
    input  logic                    Clk_CI,
    input  logic                    Rst_RI,
    input  logic                    Div_start_SI,
    input  logic                    Sqrt_start_SI,
    input  logic [C_DIV_RM-1:0]     RM_SI,
    input  logic [PREC_W-1:0]       Precision_ctl_SI,
    input  logic                    Special_case_SI,
    input  logic                    Kill_SI,
    input  logic                    Ready_SI,
    output logic                    Ready_SO,
    output logic                    Busy_SO,
    output logic                    Op_div_SO,
    output logic [C_DIV_RM-1:0]     RM_SO,
    output logic                    Load_SO,
    output logic                    Iter_en_SO,
    output logic [C_DIV_ITER_W-1:0] Iter_cnt_DO,
    output logic                    Norm_en_SO,
    output logic                    Valid_SO
);

    div_sqrt_state_t         state_q, state_d;
    div_sqrt_op_t            op_q, op_d;
    logic [C_DIV_ITER_W-1:0] n_q, n_d, n_c;
    logic                    busy_q, busy_d;
    logic                    iter_en_q, iter_en_d;
    logic                    norm_en_q, norm_en_d;
    logic                    valid_q, valid_d;
    logic                    accept_c, cnt_clear_c, cnt_en_c, cnt_last_c;
    logic [31:0]             prec_c;

    // Iteration count: full precision for 0 or oversize requests, clamped below
    always_comb begin
        prec_c = 32'(Precision_ctl_SI);
        if (prec_c == 32'd0 || prec_c > MANT_W) begin
            n_c = C_DIV_ITER_W'(MANT_W + GUARD_IT);
        end else if (prec_c < C_DIV_MIN_PREC) begin
            n_c = C_DIV_ITER_W'(C_DIV_MIN_PREC + GUARD_IT);
        end else begin
            n_c = C_DIV_ITER_W'(prec_c + GUARD_IT);
        end
    end

    assign Ready_SO = (state_q == IDLE) | ((state_q == DONE) & Ready_SI);
    assign accept_c = Ready_SO & (Div_start_SI | Sqrt_start_SI) & ~Kill_SI;
    assign Load_SO  = accept_c;

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        n_d     = n_q;
        if (accept_c) begin
            op_d = '{op_div: Div_start_SI, rm: RM_SI};
            n_d  = n_c;
        end
        unique case (state_q)
            IDLE: if (accept_c) state_d = Special_case_SI ? NORM : ITER;
            ITER: if (cnt_last_c) state_d = NORM;
            NORM: state_d = DONE;
            DONE: begin
                if (Ready_SI) begin
                    if (accept_c) state_d = Special_case_SI ? NORM : ITER;
                    else          state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (Kill_SI) state_d = IDLE;
        busy_d      = (state_d != IDLE);
        iter_en_d   = (state_d == ITER);
        norm_en_d   = (state_d == NORM);
        valid_d     = (state_d == DONE);
        cnt_clear_c = accept_c | (state_d != ITER);
        cnt_en_c    = (state_q == ITER);
    end

    always_ff @(posedge Clk_CI or posedge Rst_RI) begin
        if (Rst_RI) begin
            state_q   <= IDLE;
            op_q      <= '0;
            n_q       <= '0;
            busy_q    <= 1'b0;
            iter_en_q <= 1'b0;
            norm_en_q <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            n_q       <= n_d;
            busy_q    <= busy_d;
            iter_en_q <= iter_en_d;
            norm_en_q <= norm_en_d;
            valid_q   <= valid_d;
        end
    end

    fpu_iter_cnt_div_sqrt #(.W(C_DIV_ITER_W)) i_iter_cnt (
        .clk_i    (Clk_CI),
        .rst_i    (Rst_RI),
        .clear_i  (cnt_clear_c),
        .en_i     (cnt_en_c),
        .limit_i  (n_q),
        .count_o  (Iter_cnt_DO),
        .last_c_o (cnt_last_c)
    );

    assign Busy_SO    = busy_q;
    assign Op_div_SO  = op_q.op_div;
    assign RM_SO      = op_q.rm;
    assign Iter_en_SO = iter_en_q;
    assign Norm_en_SO = norm_en_q;
    assign Valid_SO   = valid_q;

endmodule
